sccb_arbiter: RTL and testbench
===============================

SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 65535, max cycles spent in GRANT+WAIT before abort (used only when SCCB_ARB_TIMEOUT_EN is defined).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 req0, req1  input  1 each  requester N wants one SCCB transaction; level, held until doneN.
REQ-005 addr0/addr1, sub_addr0/sub_addr1, data_wr0/data_wr1  input  8 each  requester N device address, register address, write data.
REQ-006 rw0, rw1  input  1 each  requester N direction; 0 = write, 1 = read.
REQ-007 done0, done1  output  1 each  one-cycle pulse; requester N transaction finished.
REQ-008 rdata0, rdata1  output  8 each  read data returned to requester N, valid from doneN until its next doneN.
REQ-009 err0, err1  output  1 each  ack error or timeout for requester N, valid with rdataN.
REQ-010 ena, rw  output  1 each  to SCCB master: start strobe, direction.
REQ-011 addr, sub_addr, data_wr  output  8 each  to SCCB master: transaction fields.
REQ-012 busy, ack_err  input  1 each  from SCCB master: transaction in progress, slave NACK seen.
REQ-013 data_rd  input  8  from SCCB master: read byte.

Function
REQ-014 States: IDLE, GRANT, WAIT, DONE; encoded in 2 bits.
REQ-015 IDLE: no req -> stay; one req -> grant it; both req -> grant the port not granted last (after reset: port 0 first).
REQ-016 On entering GRANT, grantee's addr/sub_addr/data_wr/rw are latched into the master outputs and held constant until the next grant.
REQ-017 GRANT: ena=1; on busy=1, ena=0 in the next cycle and move to WAIT; otherwise stay.
REQ-018 WAIT: ena=0; on busy=0, capture data_rd into rdataN and ack_err into errN, move to DONE.
REQ-019 DONE: doneN=1 for exactly this cycle, update last-granted = N, return to IDLE.
REQ-020 Minimum latency from reqN rising (bus idle) to doneN: 4 cycles plus the cycles busy stays high.
REQ-021 reqN dropped before grant: request is discarded, no doneN; reqN dropped after grant: transaction completes, doneN still pulses.
REQ-022 A requester still asserting req in the DONE cycle is treated as a new request in IDLE; round-robin guarantees the other port wins if it is also requesting.
REQ-023 done0 and done1 are never high in the same cycle; ena is never high outside GRANT.
REQ-024 Non-granted requester's rdata/err hold their previous values.

Reset
REQ-025 rst_n=0 asynchronously forces: state=IDLE, ena=0, rw=0, addr=sub_addr=data_wr=0x00, done0=done1=0, rdata0=rdata1=0x00, err0=err1=0, last-granted=port 1, timeout counter=0.
REQ-026 Reset mid-transaction drops ena immediately; no done pulse is produced for the aborted transaction after release.
REQ-027 First arbitration after rst_n rises happens on the first clock edge with rst_n=1.

Configuration
REQ-028 Macro SCCB_ARB_TIMEOUT_EN defined: 16-bit counter clears on entering GRANT, counts each cycle in GRANT/WAIT; on reaching TIMEOUT_CYCLES, ena=0, errN=1, rdataN=0x00, go to DONE (doneN pulses).
REQ-029 SCCB_ARB_TIMEOUT_EN undefined: no counter logic; GRANT/WAIT wait indefinitely on busy.

Verification
REQ-030 req0 write (addr 0xC0, sub 0x11, data 0x04), busy high 10 cycles -> ena high until busy seen, master fields match, done0 single pulse, err0=0.
REQ-031 req0 and req1 asserted same cycle after reset, held -> port 0 served first, then port 1, then port 0 again (alternation).
REQ-032 req1 read (rw=1, sub 0x0A), data_rd=0x7F, ack_err=1 at busy fall -> rdata1=0x7F, err1=1, rdata0/err0 unchanged.
REQ-033 rst_n pulsed low during WAIT -> ena=0 and all outputs at reset values asynchronously; no done after release.
REQ-034 SCCB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=20, busy never asserted -> done0 on cycle ~21 after grant, err0=1, rdata0=0x00; undefined -> ena stays high, no done.

Source files
------------

// File: rtl/sccb_arbiter.sv
`timescale 1ns/1ps
// Purpose: round-robin arbiter sharing one SCCB master between two requesters.
// Latency: reqN -> ena in 1 cycle; doneN one cycle after busy falls.
// Backpressure: reqN is level-held until doneN; the loser waits in IDLE.
//
// Ports: clk/rst_n (async active-low); req/addr/sub_addr/data_wr/rw per
// requester in; done/rdata/err per requester out; ena/rw/addr/sub_addr/data_wr
// to the SCCB master; busy/ack_err/data_rd back from it.
// Optional feature: define SCCB_ARB_TIMEOUT_EN to abort a transaction that
// spends TIMEOUT_CYCLES in GRANT+WAIT (reported as err=1, rdata=0x00).
module sccb_arbiter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] sub_addr0,
  input  logic [7:0] sub_addr1,
  input  logic [7:0] data_wr0,
  input  logic [7:0] data_wr1,
  input  logic       rw0,
  input  logic       rw1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err0,
  output logic       err1,
  output logic       ena,
  output logic       rw,
  output logic [7:0] addr,
  output logic [7:0] sub_addr,
  output logic [7:0] data_wr,
  input  logic       busy,
  input  logic       ack_err,
  input  logic [7:0] data_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;    // port currently being served
  logic       last_q, last_d;  // port served most recently
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] sub_addr_q, sub_addr_d;
  logic [7:0] data_wr_q, data_wr_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;
  logic       err0_q, err0_d;
  logic       err1_q, err1_d;
  logic       pick;
  logic       timeout;

`ifdef SCCB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == 16'(TIMEOUT_CYCLES));

  // Zero while idle so it starts from 0 on entering GRANT; counts every
  // GRANT/WAIT cycle. DONE leaves it alone, IDLE clears it again.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q != DONE) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int TIMEOUT_CYCLES_UNUSED = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Both requesting: the one not served last wins. Otherwise whoever asks.
  assign pick = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    sub_addr_d = sub_addr_q;
    data_wr_d  = data_wr_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    err0_d     = err0_q;
    err1_d     = err1_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d    = GRANT;
          gnt_d      = pick;
          rw_d       = pick ? rw1       : rw0;
          addr_d     = pick ? addr1     : addr0;
          sub_addr_d = pick ? sub_addr1 : sub_addr0;
          data_wr_d  = pick ? data_wr1  : data_wr0;
        end
      end
      GRANT: begin
        if (timeout) begin
          state_d = DONE;
          if (gnt_q) begin rdata1_d = 8'h00; err1_d = 1'b1; end
          else       begin rdata0_d = 8'h00; err0_d = 1'b1; end
        end else if (busy) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A completion seen on the same cycle as the timeout wins.
        if (!busy) begin
          state_d = DONE;
          if (gnt_q) begin rdata1_d = data_rd; err1_d = ack_err; end
          else       begin rdata0_d = data_rd; err0_d = ack_err; end
        end else if (timeout) begin
          state_d = DONE;
          if (gnt_q) begin rdata1_d = 8'h00; err1_d = 1'b1; end
          else       begin rdata0_d = 8'h00; err0_d = 1'b1; end
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      rw_q       <= 1'b0;
      addr_q     <= 8'h00;
      sub_addr_q <= 8'h00;
      data_wr_q  <= 8'h00;
      rdata0_q   <= 8'h00;
      rdata1_q   <= 8'h00;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      sub_addr_q <= sub_addr_d;
      data_wr_q  <= data_wr_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
    end
  end

  // Strobes decode straight from registered state, so reset kills them at once.
  assign ena      = (state_q == GRANT);
  assign done0    = (state_q == DONE) && !gnt_q;
  assign done1    = (state_q == DONE) &&  gnt_q;
  assign rw       = rw_q;
  assign addr     = addr_q;
  assign sub_addr = sub_addr_q;
  assign data_wr  = data_wr_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
`timescale 1ns/1ps
module tb_sccb_arbiter;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, rw0, rw1;
  logic [7:0] addr0, addr1, sub_addr0, sub_addr1, data_wr0, data_wr1;
  logic       done0, done1, err0, err1, ena, rw;
  logic [7:0] rdata0, rdata1, addr, sub_addr, data_wr;
  logic       busy, ack_err;
  logic [7:0] data_rd;

  always #5 clk = ~clk;

  sccb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .sub_addr0(sub_addr0), .sub_addr1(sub_addr1),
    .data_wr0(data_wr0), .data_wr1(data_wr1),
    .rw0(rw0), .rw1(rw1),
    .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .ena(ena), .rw(rw), .addr(addr), .sub_addr(sub_addr), .data_wr(data_wr),
    .busy(busy), .ack_err(ack_err), .data_rd(data_rd)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: what each requester should currently see, and who
  // was served last (round-robin memory).
  logic [7:0] rdata_exp [2];
  logic       err_exp   [2];
  int         last_exp;

  typedef struct {
    logic       r0, r1;
    logic [7:0] a0, s0, d0;
    logic       w0;
    logic [7:0] a1, s1, d1;
    logic       w1;
    int         blen;
    logic [7:0] rd;
    logic       ae;
    logic       early_drop;
    int         exp_port;
  } vec_t;

  vec_t vt [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int model_pick(input logic r0, input logic r1);
    if (r0 && r1) return 1 - last_exp;
    if (r0)       return 0;
    return 1;
  endfunction

  task automatic model_reset();
    rdata_exp[0] = 8'h00; rdata_exp[1] = 8'h00;
    err_exp[0]   = 1'b0;  err_exp[1]   = 1'b0;
    last_exp     = 1;
  endtask

  // Plays the SCCB master for one transaction and checks the outcome.
  task automatic run_txn(input logic r0, input logic r1, input int blen,
                         input logic [7:0] rd, input logic ae,
                         input logic early_drop, output int got);
    int p, n, lat;
    logic [7:0] ea, es, ed;
    logic er;
    got = -1;
    p  = model_pick(r0, r1);
    ea = (p == 1) ? addr1 : addr0;
    es = (p == 1) ? sub_addr1 : sub_addr0;
    ed = (p == 1) ? data_wr1 : data_wr0;
    er = (p == 1) ? rw1 : rw0;
    n = 0;
    lat = 0;
    while (!ena && n < 20) begin tick(); n++; end
    lat = n;
    chk("ena_seen", 32'(ena), 32'd1);
    if (!ena) return;
    chk("m_addr", 32'(addr), 32'(ea));
    chk("m_sub", 32'(sub_addr), 32'(es));
    chk("m_data", 32'(data_wr), 32'(ed));
    chk("m_rw", 32'(rw), 32'(er));
    if (early_drop) begin req0 = 1'b0; req1 = 1'b0; end
    busy = 1'b1;
    tick(); lat++;
    chk("ena_drop", 32'(ena), 32'd0);
    for (int i = 1; i < blen; i++) begin tick(); lat++; end
    chk("fields_held", 32'({addr, sub_addr, data_wr}), 32'({ea, es, ed}));
    busy = 1'b0; data_rd = rd; ack_err = ae;
    tick(); lat++;
    chk("latency_bound", 32'(lat <= blen + 4), 32'd1);
    chk("done0", 32'(done0), 32'(p == 0));
    chk("done1", 32'(done1), 32'(p == 1));
    if (done0 && !done1) got = 0;
    if (done1 && !done0) got = 1;
    rdata_exp[p] = rd;
    err_exp[p]   = ae;
    last_exp     = p;
    chk("rdata0", 32'(rdata0), 32'(rdata_exp[0]));
    chk("rdata1", 32'(rdata1), 32'(rdata_exp[1]));
    chk("err0", 32'(err0), 32'(err_exp[0]));
    chk("err1", 32'(err1), 32'(err_exp[1]));
    data_rd = 8'h00; ack_err = 1'b0;
    tick();
    chk("done_single", 32'({done0, done1}), 32'd0);
  endtask

  task automatic wait_ena(output int n);
    n = 0;
    while (!ena && n < 20) begin tick(); n++; end
  endtask

  initial begin
    int got, n, seen;
    logic [1:0] r;

    rst_n = 1'b0; req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
    addr0 = 0; addr1 = 0; sub_addr0 = 0; sub_addr1 = 0; data_wr0 = 0; data_wr1 = 0;
    busy = 0; ack_err = 0; data_rd = 0;
    model_reset();

    vt[0] = '{1, 0, 8'hC0, 8'h11, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0, 10, 8'h00, 0, 0, 0};
    vt[1] = '{0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h42, 8'h0A, 8'h00, 1,  3, 8'h7F, 1, 0, 1};
    vt[2] = '{1, 1, 8'h21, 8'h22, 8'h23, 0, 8'h31, 8'h32, 8'h33, 1,  2, 8'hA5, 0, 0, 0};
    vt[3] = '{1, 1, 8'h44, 8'h45, 8'h46, 1, 8'h54, 8'h55, 8'h56, 0,  1, 8'h3C, 0, 0, 1};
    vt[4] = '{1, 0, 8'h60, 8'h61, 8'h62, 1, 8'h00, 8'h00, 8'h00, 0,  5, 8'h5A, 1, 1, 0};

    #2;
    chk("rst_ena", 32'(ena), 32'd0);
    chk("rst_done", 32'({done0, done1}), 32'd0);
    chk("rst_fields", 32'({rw, addr, sub_addr, data_wr}), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1, err0, err1}), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Table-driven transactions.
    for (int v = 0; v < 5; v++) begin
      addr0 = vt[v].a0; sub_addr0 = vt[v].s0; data_wr0 = vt[v].d0; rw0 = vt[v].w0;
      addr1 = vt[v].a1; sub_addr1 = vt[v].s1; data_wr1 = vt[v].d1; rw1 = vt[v].w1;
      req0 = vt[v].r0; req1 = vt[v].r1;
      run_txn(vt[v].r0, vt[v].r1, vt[v].blen, vt[v].rd, vt[v].ae, vt[v].early_drop, got);
      req0 = 1'b0; req1 = 1'b0;
      chk("vec_port", 32'(got), 32'(vt[v].exp_port));
    end

    // Loser of the last contention dropped its request before being granted.
    seen = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (ena || done0 || done1) seen = 1; end
    chk("dropped_req_idle", 32'(seen), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 30; k++) begin
      r = 2'($urandom_range(1, 3));
      {addr0, sub_addr0, data_wr0} = 24'($urandom);
      {addr1, sub_addr1, data_wr1} = 24'($urandom);
      rw0 = 1'($urandom); rw1 = 1'($urandom);
      req0 = r[0]; req1 = r[1];
      run_txn(r[0], r[1], $urandom_range(1, 6), 8'($urandom), 1'($urandom), 1'b0, got);
      req0 = 1'b0; req1 = 1'b0;
    end

    // Reset, then both held: 0, 1, 0 alternation.
    rst_n = 1'b0; tick(); rst_n = 1'b1; model_reset();
    addr0 = 8'hA0; sub_addr0 = 8'h01; data_wr0 = 8'h10; rw0 = 0;
    addr1 = 8'hB0; sub_addr1 = 8'h02; data_wr1 = 8'h20; rw1 = 1;
    req0 = 1'b1; req1 = 1'b1;
    run_txn(1, 1, 2, 8'h11, 0, 0, got); chk("alt_first", 32'(got), 32'd0);
    run_txn(1, 1, 2, 8'h22, 0, 0, got); chk("alt_second", 32'(got), 32'd1);
    run_txn(1, 1, 2, 8'h33, 1, 1, got); chk("alt_third", 32'(got), 32'd0);
    req0 = 1'b0; req1 = 1'b0;

    // Reset pulsed while the master is busy.
    addr0 = 8'hC4; sub_addr0 = 8'h55; data_wr0 = 8'h66;
    req0 = 1'b1;
    wait_ena(n);
    chk("rstw_ena", 32'(ena), 32'd1);
    busy = 1'b1;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ena_low", 32'(ena), 32'd0);
    chk("rstw_fields", 32'({rw, addr, sub_addr, data_wr}), 32'd0);
    chk("rstw_rdata", 32'({rdata0, rdata1, err0, err1}), 32'd0);
    chk("rstw_done", 32'({done0, done1}), 32'd0);
    req0 = 1'b0;
    tick();
    busy = 1'b0;
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (done0 || done1 || ena) seen = 1; end
    chk("rstw_no_done", 32'(seen), 32'd0);

    // Master never answers.
    addr0 = 8'h12; sub_addr0 = 8'h34; data_wr0 = 8'h56; rw0 = 1;
    req0 = 1'b1;
    wait_ena(n);
    chk("to_ena", 32'(ena), 32'd1);
`ifdef SCCB_ARB_TIMEOUT_EN
    n = 0;
    while (!done0 && n < 40) begin tick(); n++; end
    chk("to_window", 32'(n >= TO - 1 && n <= TO + 3), 32'd1);
    chk("to_done0", 32'({done0, done1}), 32'b10);
    chk("to_err0", 32'(err0), 32'd1);
    chk("to_rdata0", 32'(rdata0), 32'd0);
    req0 = 1'b0;
    tick();
`else
    seen = 0;
    for (int i = 0; i < 2 * TO; i++) begin tick(); if (done0 || done1) seen = 1; end
    chk("nto_ena_high", 32'(ena), 32'd1);
    chk("nto_no_done", 32'(seen), 32'd0);
    req0 = 1'b0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
